// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Loadable instruction memory for the VSM CPU. A host streams program words in
// over a valid/ready port. The block stores and counts them, then switches to
// run mode, where the CPU fetches through a registered read port. Any location
// that was not written during the current load session reads back as FILL.
//
// Parameters
//   DATA_W  instruction word width
//   DEPTH   number of memory words (need not be a power of two)
//   FILL    word returned for locations not written in the current load
//   ADDR_W  derived, $clog2(DEPTH)
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_start  one-cycle pulse, begins (or restarts) a load session
//   ld_valid    ld_data holds a program word
//   ld_data     program word
//   ld_last     final word of the session (qualified by ld_valid)
//   ld_ready    a word is accepted this cycle when ld_valid is high
//   rd_en       fetch request (honoured only in RUN)
//   rd_addr     fetch address
//   rd_data     fetched word, registered, holds between fetches
//   rd_valid    one-cycle pulse: rd_data was updated by a fetch
//   load_done   high while in RUN
//   word_count  words written in the last/current session
//   checksum    XOR of the words accepted in the session
//
// Build option
//   INSTR_MEM_CHECKSUM_EN  when defined, checksum is a running XOR of accepted
//                          words; otherwise checksum is tied to zero and no
//                          register exists for it.
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int                 DATA_W = 8,
    parameter int                 DEPTH  = 16,
    parameter logic [DATA_W-1:0]  FILL   = '0,
    localparam int                ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Count value at which the word being accepted fills the last location.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word_p0;

    // Storage carries no reset; word_count alone says which entries are live.
    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // load_start has priority everywhere: it (re)enters LOAD, and any word
    // or fetch presented in the same cycle is dropped.
    always_comb begin
        state_d   = state_q;
        ld_ready  = 1'b0;
        load_done = 1'b0;
        accept    = 1'b0;
        rd_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (load_start) begin
                    state_d = LOAD;
                end else if (ld_valid) begin
                    accept = 1'b1;
                    // Leaving on the DEPTH-th word means the pointer never wraps.
                    if (ld_last || (word_count == LAST_CNT)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                load_done = 1'b1;
                if (load_start) begin
                    state_d = LOAD;
                end else begin
                    rd_fire = rd_en;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Load path: word_count doubles as the write pointer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (load_start) begin
            word_count <= '0;
        end else if (accept) begin
            word_count <= word_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[word_count[ADDR_W-1:0]] <= ld_data;
        end
    end

`ifdef INSTR_MEM_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (load_start) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q ^ ld_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    // ---------------------------------------------------------------------
    // Fetch stage p0: select stored word or FILL
    // ---------------------------------------------------------------------
    // Since word_count never exceeds DEPTH, passing the compare also keeps
    // the array index in range when DEPTH is not a power of two.
    always_comb begin
        rd_word_p0 = FILL;
        if ({1'b0, rd_addr} < word_count) begin
            rd_word_p0 = mem[rd_addr];
        end
    end

    // ---------------------------------------------------------------------
    // Fetch stage p1: registered read port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_word_p0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam logic [7:0] FILL = 8'h00;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              load_done;
    logic [ADDR_W:0]   word_count;
    logic [DATA_W-1:0] checksum;

    int checks = 0;
    int errors = 0;

    instr_mem_loader #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .FILL  (FILL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_start(load_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .load_done (load_done),
        .word_count(word_count),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ls;
        logic       v;
        logic [7:0] d;
        logic       last;
        logic       re;
        logic [3:0] ra;
        logic       e_rdy;
        logic       e_done;
        logic       e_rv;
        logic [7:0] e_rd;
        logic [4:0] e_wc;
        logic [7:0] e_cs;   // value with the checksum feature enabled
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ls, logic v, logic [7:0] d, logic last,
                                logic re, logic [3:0] ra, logic e_rdy,
                                logic e_done, logic e_rv, logic [7:0] e_rd,
                                logic [4:0] e_wc, logic [7:0] e_cs);
        vec_t r;
        r.ls = ls; r.v = v; r.d = d; r.last = last; r.re = re; r.ra = ra;
        r.e_rdy = e_rdy; r.e_done = e_done; r.e_rv = e_rv; r.e_rd = e_rd;
        r.e_wc = e_wc; r.e_cs = e_cs;
        return r;
    endfunction

    function automatic logic [7:0] cs_exp(input logic [7:0] v);
`ifdef INSTR_MEM_CHECKSUM_EN
        return v;
`else
        return (v & 8'h00);
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ls, input logic v, input logic [7:0] d,
                         input logic last, input logic re, input logic [3:0] ra);
        load_start = ls;
        ld_valid   = v;
        ld_data    = d;
        ld_last    = last;
        rd_en      = re;
        rd_addr    = ra;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_rdy,
                           input logic e_done, input logic e_rv,
                           input logic [7:0] e_rd, input logic [4:0] e_wc,
                           input logic [7:0] e_cs);
        chk({tag, ".ld_ready"},   32'(ld_ready),   32'(e_rdy));
        chk({tag, ".load_done"},  32'(load_done),  32'(e_done));
        chk({tag, ".rd_valid"},   32'(rd_valid),   32'(e_rv));
        chk({tag, ".rd_data"},    32'(rd_data),    32'(e_rd));
        chk({tag, ".word_count"}, 32'(word_count), 32'(e_wc));
        chk({tag, ".checksum"},   32'(checksum),   32'(cs_exp(e_cs)));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 8'h00, 0, 0, 4'd0);

        //              ls v  d      lst re ra     rdy dn rv rd     wc  cs
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd0,  0, 0, 0, 8'h00, 0, 8'h00)); // read in IDLE
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 4'd0,  1, 0, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0, 4'd0,  1, 0, 0, 8'h00, 1, 8'h55));
        vecs.push_back(mk(0, 1, 8'h12, 0, 0, 4'd0,  1, 0, 0, 8'h00, 2, 8'h47));
        vecs.push_back(mk(0, 1, 8'h30, 0, 0, 4'd0,  1, 0, 0, 8'h00, 3, 8'h77));
        vecs.push_back(mk(0, 1, 8'h28, 1, 0, 4'd0,  0, 1, 0, 8'h00, 4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd4,  0, 1, 1, FILL,  4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd5,  0, 1, 1, FILL,  4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd0,  0, 1, 1, 8'h55, 4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd1,  0, 1, 1, 8'h12, 4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd2,  0, 1, 1, 8'h30, 4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd3,  0, 1, 1, 8'h28, 4, 8'h5F));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 4'd0,  0, 1, 0, 8'h28, 4, 8'h5F)); // rd_data holds
        vecs.push_back(mk(0, 1, 8'h99, 0, 0, 4'd0,  0, 1, 0, 8'h28, 4, 8'h5F)); // ld_valid ignored in RUN
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd15, 0, 1, 1, FILL,  4, 8'h5F));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 4'd0,  1, 0, 0, FILL,  0, 8'h00)); // load_start beats rd_en
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 4'd0,  1, 0, 0, FILL,  1, 8'h11));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 4'd0,  1, 0, 0, FILL,  2, 8'h33));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0, 4'd0,  1, 0, 0, FILL,  3, 8'h77));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 4'd0,  1, 0, 0, FILL,  0, 8'h00)); // restart in LOAD
        vecs.push_back(mk(0, 1, 8'hA0, 0, 0, 4'd0,  1, 0, 0, FILL,  1, 8'hA0));
        vecs.push_back(mk(0, 1, 8'hA1, 1, 0, 4'd0,  0, 1, 0, FILL,  2, 8'h01));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd2,  0, 1, 1, FILL,  2, 8'h01)); // stale 44 hidden
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd1,  0, 1, 1, 8'hA1, 2, 8'h01));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd0,  0, 1, 1, 8'hA0, 2, 8'h01));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd3,  0, 1, 1, FILL,  2, 8'h01));
        vecs.push_back(mk(1, 1, 8'h77, 0, 0, 4'd0,  1, 0, 0, FILL,  0, 8'h00)); // word with load_start dropped
        vecs.push_back(mk(0, 1, 8'h5A, 1, 0, 4'd0,  0, 1, 0, FILL,  1, 8'h5A));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 4'd0,  0, 1, 1, 8'h5A, 1, 8'h5A));

        // Reset state
        step();
        chk_all("reset_hold", 0, 0, 0, 8'h00, 0, 8'h00);
        #2 rst_n = 1'b1;
        step();
        chk_all("reset_rel", 0, 0, 0, 8'h00, 0, 8'h00);

        // Table-driven main sequence
        foreach (vecs[i]) begin
            drive(vecs[i].ls, vecs[i].v, vecs[i].d, vecs[i].last,
                  vecs[i].re, vecs[i].ra);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_done,
                    vecs[i].e_rv, vecs[i].e_rd, vecs[i].e_wc, vecs[i].e_cs);
        end

        // Stream 17 words with no ld_last: RUN after the 16th
        begin
            logic [7:0] cs;
            cs = 8'h00;
            drive(1, 0, 8'h00, 0, 0, 4'd0);
            step();
            chk("full.start_rdy", 32'(ld_ready), 32'd1);
            for (int i = 0; i < 17; i++) begin
                drive(0, 1, 8'(8'h80 + i), 0, 0, 4'd0);
                if (i < 16) cs = cs ^ 8'(8'h80 + i);
                step();
                chk($sformatf("full%0d.wc", i), 32'(word_count),
                    (i < 16) ? 32'(i + 1) : 32'd16);
                chk($sformatf("full%0d.done", i), 32'(load_done),
                    (i >= 15) ? 32'd1 : 32'd0);
                chk($sformatf("full%0d.rdy", i), 32'(ld_ready),
                    (i >= 15) ? 32'd0 : 32'd1);
            end
            chk("full.cs", 32'(checksum), 32'(cs_exp(cs)));
            drive(0, 0, 8'h00, 0, 1, 4'd15);
            step();
            chk("full.rd15.valid", 32'(rd_valid), 32'd1);
            chk("full.rd15.data", 32'(rd_data), 32'h8F);
            drive(0, 0, 8'h00, 0, 1, 4'd0);
            step();
            chk("full.rd0.data", 32'(rd_data), 32'h80);
        end

        // Reset in the middle of a load, then reload
        drive(1, 0, 8'h00, 0, 0, 4'd0);
        step();
        drive(0, 1, 8'hC1, 0, 0, 4'd0);
        step();
        drive(0, 1, 8'hC2, 0, 0, 4'd0);
        step();
        chk("mid.wc_before", 32'(word_count), 32'd2);
        drive(0, 0, 8'h00, 0, 0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.async_wc", 32'(word_count), 32'd0);
        chk("mid.async_done", 32'(load_done), 32'd0);
        chk("mid.async_rdy", 32'(ld_ready), 32'd0);
        chk("mid.async_cs", 32'(checksum), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(0, 0, 8'h00, 0, 1, 4'd0);
        step();
        chk_all("mid.idle_read", 0, 0, 0, 8'h00, 0, 8'h00);
        drive(1, 0, 8'h00, 0, 0, 4'd0);
        step();
        chk("mid.reload_rdy", 32'(ld_ready), 32'd1);
        drive(0, 1, 8'h3C, 1, 0, 4'd0);
        step();
        chk_all("mid.reload", 0, 1, 0, 8'h00, 1, 8'h3C);
        drive(0, 0, 8'h00, 0, 1, 4'd0);
        step();
        chk_all("mid.rd0", 0, 1, 1, 8'h3C, 1, 8'h3C);
        drive(0, 0, 8'h00, 0, 1, 4'd1);
        step();
        chk_all("mid.rd1", 0, 1, 1, FILL, 1, 8'h3C);
        drive(0, 0, 8'h00, 0, 0, 4'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
